// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock,
// runtime signed/unsigned mode, start/done handshake, 2*WIDTH-bit product.
module booth_mult_seq #(
    parameter int  WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   op_a_in,
    input  logic [WIDTH-1:0]   op_b_in,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         dbg_state
);

    localparam int EW = WIDTH + 1;
    localparam int AW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      a_q, a_d;
    logic [EW-1:0]      q_q, q_d;
    logic [EW-1:0]      m_q, m_d;
    logic               qm1_q, qm1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [EW-1:0]      ext_a, ext_b;
    logic [AW-1:0]      m_sext;
    logic [AW-1:0]      sum;

    // In unsigned mode the extra top bit is zero, so the signed Booth core
    // multiplies both operand kinds without special cases.
    assign ext_a  = {is_signed & op_a_in[WIDTH-1], op_a_in};
    assign ext_b  = {is_signed & op_b_in[WIDTH-1], op_b_in};
    assign m_sext = {m_q[EW-1], m_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        sum       = a_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d     = ext_a;
                    q_d     = ext_b;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                case ({q_q[0], qm1_q})
                    2'b01:   sum = a_q + m_sext;
                    2'b10:   sum = a_q - m_sext;
                    default: sum = a_q;
                endcase
                a_d   = {sum[AW-1], sum[AW-1:1]};
                q_d   = {sum[0], q_q[EW-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                // Low 2*WIDTH bits of the post-shift {A, Q}.
                if (cnt_q == CNT_W'(WIDTH)) begin
                    product_d = {a_d[WIDTH-2:0], q_d};
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready     = (state_q == IDLE) || (state_q == DONE);
    assign done      = (state_q == DONE);
    assign product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: a WIDTH=16 instance for the main vectors
// and handshake cases, plus a WIDTH=4 instance checked against a small model.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start16, sg16;
    logic [15:0] a16, b16;
    logic        ready16, done16;
    logic [31:0] product16;
    logic [1:0]  dbg16;

    logic        start4, sg4;
    logic [3:0]  a4, b4;
    logic        ready4, done4;
    logic [7:0]  product4;
    logic [1:0]  dbg4;

    int n_chk  = 0;
    int n_pass = 0;

    booth_mult_seq #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start16),
        .is_signed (sg16),
        .op_a_in   (a16),
        .op_b_in   (b16),
        .ready     (ready16),
        .done      (done16),
        .product   (product16),
        .dbg_state (dbg16)
    );

    booth_mult_seq #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .is_signed (sg4),
        .op_a_in   (a4),
        .op_b_in   (b4),
        .ready     (ready4),
        .done      (done4),
        .product   (product4),
        .dbg_state (dbg4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge just after the capture edge; returns at the negedge
    // where done is seen (or the budget ran out), lat counts edges since capture.
    task automatic wait_done16(inout int lat);
        while (!done16 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [31:0] exp, input bit disturb);
        int lat;
        logic [31:0] prev;
        prev = product16;
        @(negedge clk);
        a16 = a; b16 = b; sg16 = s; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        lat = 0;
        check({tag, "_busy"}, ready16, 1'b0);
        if (disturb) begin
            a16 = ~a; b16 = ~b; sg16 = ~s;
            @(negedge clk); lat++;
            start16 = 1'b1;
            @(negedge clk); lat++;
            start16 = 1'b0;
            check({tag, "_prod_stable"}, product16, prev);
        end
        wait_done16(lat);
        check({tag, "_lat"}, lat, 17);
        check({tag, "_prod"}, product16, exp);
        @(negedge clk);
        check({tag, "_pulse"}, {done16, ready16}, 2'b01);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int lat;
        int sa, sb;
        logic [7:0] exp;
        sa  = s ? int'($signed(a)) : int'(a);
        sb  = s ? int'($signed(b)) : int'(b);
        exp = 8'(sa * sb);
        @(negedge clk);
        a4 = a; b4 = b; sg4 = s; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("w4_lat_%0h_%0h_%0d", a, b, s), lat, 5);
        check($sformatf("w4_prod_%0h_%0h_%0d", a, b, s), product4, exp);
    endtask

    initial begin
        int lat;
        int seen;
        rst_n = 1'b0;
        start16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
        start4  = 1'b0; sg4  = 1'b0; a4  = '0; b4  = '0;
        #12;
        check("rst_ready", ready16, 1'b1);
        check("rst_done", done16, 1'b0);
        check("rst_product", product16, 32'h0);
        check("rst_state", dbg16, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run16("u_1034x526", 16'd1034, 16'd526, 1'b0, 32'h00084C8C, 1'b0);
        run16("u_ffffxffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0);
        run16("s_ffffxffff", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0);
        run16("s_m3x5", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b0);
        run16("s_8000x8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b0);
        run16("s_8000x7fff", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 1'b0);
        run16("u_8000x7fff", 16'h8000, 16'h7FFF, 1'b0, 32'h3FFF8000, 1'b0);
        run16("u_disturb", 16'd1034, 16'd526, 1'b0, 32'h00084C8C, 1'b1);
        run16("s_disturb", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b1);

        // Back-to-back: start held through DONE, new op accepted with no gap.
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h0010; sg16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        lat = 0;
        start16 = 1'b0;
        wait_done16(lat);
        check("b2b_first_lat", lat, 17);
        check("b2b_first_prod", product16, 32'h00012340);
        a16 = 16'h0003; b16 = 16'hFFFE; sg16 = 1'b1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        lat = 0;
        check("b2b_accept", {done16, ready16}, 2'b00);
        check("b2b_prod_held", product16, 32'h00012340);
        wait_done16(lat);
        check("b2b_second_lat", lat, 17);
        check("b2b_second_prod", product16, 32'hFFFFFFFA);

        // Reset mid-CALC aborts the multiply.
        @(negedge clk);
        a16 = 16'd1034; b16 = 16'd526; sg16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", ready16, 1'b1);
        check("midrst_done", done16, 1'b0);
        check("midrst_product", product16, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done16) seen++;
        end
        check("midrst_no_done", seen, 0);
        run16("post_rst", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0);

        // WIDTH=4 corners, then random pairs in both modes.
        run4(4'h8, 4'h8, 1'b1);
        run4(4'hF, 4'hF, 1'b0);
        run4(4'h8, 4'h7, 1'b1);
        for (int i = 0; i < 12; i++) begin
            run4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Sequential radix-2 Booth multiplier, parametrised in operand width, performing one add/subtract-and-shift step per clock. Successor to the fixed 17-bit combinational add/subtract datapath: it wraps an internal WIDTH+2-bit add/sub in a start/done handshake. It also adds a runtime signed/unsigned mode, so one instance serves both operand types. It sits between operand registers and any consumer needing a full 2*WIDTH-bit product at low area cost.

## Interface
- WIDTH, 16, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+2), step-counter width; derived, not overridden.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only on a rising edge where ready=1.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- op_a_in  input  WIDTH  multiplicand; sampled with start.
- op_b_in  input  WIDTH  multiplier; sampled with start.
- ready  output  1  high when no multiply is in progress (state IDLE or DONE).
- done  output  1  one-cycle pulse: product valid.
- product  output  2*WIDTH  result register; holds value until next accepted start.

## Operation
- States: IDLE, CALC, DONE. Reset -> IDLE.
- IDLE/DONE with start=1: capture operands, extended to WIDTH+1 bits. Extension is sign extension if is_signed=1, otherwise zero extension.
  - M <= ext(op_a_in).
  - Q <= ext(op_b_in).
  - A (WIDTH+2 bits) <= 0.
  - q_m1 <= 0.
  - count <= 0.
  - Go to CALC.
- DONE without start -> IDLE.
- CALC step, selected by {Q[0], q_m1}:
  - 01: A <= A + sext(M).
  - 10: A <= A - sext(M).
  - 00/11: A unchanged.
  - Then arithmetic shift right of {A, Q, q_m1} by one; MSB of A replicates.
  - count <= count + 1.
- Exactly WIDTH+1 steps are performed. On the step with count == WIDTH:
  - product <= low 2*WIDTH bits of the post-shift {A, Q}.
  - Go to DONE.
- The WIDTH+2-bit accumulator guarantees no add/sub overflow for any operand pair in either mode.
- start while in CALC is ignored; no queueing, no error flag.
- Operand and is_signed changes after the capture edge have no effect on the in-flight multiply.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - ready = 1.
  - done = 0.
  - product = 0.
  - A, Q, M, q_m1, count = 0.
- Capture edge = E0. CALC steps occur on edges E1..E(WIDTH+1).
- After E(WIDTH+1): done = 1 and product is valid. Latency is WIDTH+1 cycles from the capture edge (17 for WIDTH=16).
- done is high for exactly one cycle (the DONE state). It is never asserted in IDLE or CALC.
- ready is 0 from after E0 through E(WIDTH+1), and 1 in DONE.
- Back-to-back operation: start asserted during DONE is accepted at that edge, so a new multiply begins with zero bubble cycles. done falls on that same edge.
- product changes only on the final CALC edge; it is stable during CALC of the next operation.
- rst_n low mid-CALC aborts the multiply and forces the reset values. After rst_n rises, the first start is accepted normally.

## Test plan
- Reset: assert rst_n=0 mid-CALC of any operation -> ready=1, done=0, product=0 immediately. No done pulse appears afterwards.
- Unsigned, WIDTH=16: op_a_in=1034, op_b_in=526, is_signed=0 -> exactly 17 cycles after capture, done=1 for 1 cycle and product=32'h00084C8C (543884).
- Unsigned extremes: 16'hFFFF × 16'hFFFF, is_signed=0 -> product=32'hFFFE0001. Signed, same operands -> product=32'h00000001.
- Signed corners:
  - -3 × 5 (16'hFFFD, 16'h0005) -> 32'hFFFFFFF1.
  - 16'h8000 × 16'h8000 -> 32'h40000000.
  - 16'h8000 × 16'h7FFF -> 32'hC0008000.
- Handshake:
  - Start pulsed during CALC -> ignored; the current result is unchanged.
  - Start held during DONE -> the new op is accepted with zero gap, and its done arrives 17 cycles later.
  - Operand changes during CALC -> no effect on the result.
- Parametrisation: WIDTH=4, random signed and unsigned operand pairs -> product matches a reference model. Latency = 5 cycles.
